// File: rtl/wave_capture_ctrl.sv
// Triggered waveform capture controller: streams ADC samples into an external
// circular buffer with pre-trigger history, then reports where the frame starts.
module wave_capture_ctrl #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 10,
  parameter int PRE_TRIG    = 256,
  parameter int HOLDOFF_CYC = 6_000_000
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] ad_data,
  input  logic [1:0]        trig_mode,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              arm,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] frame_start,
  output logic              frame_valid,
  output logic              busy
);

  localparam int DEPTH    = 1 << ADDR_W;
  localparam int POST_LEN = DEPTH - PRE_TRIG;
  localparam int CNT_W    = ADDR_W + 1;
  localparam int HOLD_W   = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;

  localparam logic [CNT_W-1:0]  PRE_LAST  = CNT_W'(PRE_TRIG - 1);
  localparam logic [CNT_W-1:0]  POST_LAST = CNT_W'(POST_LEN - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYC - 1);
  localparam logic [ADDR_W-1:0] PRE_OFF   = ADDR_W'(PRE_TRIG);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ARMED,
    S_POST,
    S_HOLDOFF
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic                prev_vld_q, prev_vld_d;
  logic [1:0]          mode_q, mode_d;
  logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [ADDR_W-1:0]   frame_start_q, frame_start_d;
  logic                frame_valid_q, frame_valid_d;

  logic do_write;
  logic rise_hit, fall_hit, trig_hit;

  // A crossing needs a valid previous sample, so the first sample after an
  // empty pre-trigger phase can never trigger.
  always_comb begin
    rise_hit = (prev_q < trig_level) && (ad_data >= trig_level);
    fall_hit = (prev_q > trig_level) && (ad_data <= trig_level);
    case (mode_q)
      2'd0:    trig_hit = prev_vld_q;
      2'd3:    trig_hit = prev_vld_q && fall_hit;
      default: trig_hit = prev_vld_q && rise_hit;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    hold_d        = hold_q;
    prev_d        = prev_q;
    prev_vld_d    = prev_vld_q;
    mode_d        = mode_q;
    trig_addr_d   = trig_addr_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    frame_start_d = frame_start_q;
    frame_valid_d = 1'b0;
    do_write      = 1'b0;

    case (state_q)
      S_IDLE: begin
        prev_vld_d = 1'b0;
        cnt_d      = '0;
        hold_d     = '0;
        if ((trig_mode != 2'd2) || arm) begin
          state_d = S_PRE;
          mode_d  = trig_mode;
        end
      end
      S_PRE: begin
        if (PRE_TRIG == 0) begin
          state_d = S_ARMED;
        end else if (sample_en) begin
          do_write = 1'b1;
          if (cnt_q == PRE_LAST) begin
            cnt_d   = '0;
            state_d = S_ARMED;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_ARMED: begin
        if (sample_en) begin
          do_write = 1'b1;
          if (trig_hit) begin
            trig_addr_d = ptr_q;
            if (POST_LEN == 1) begin
              state_d       = S_HOLDOFF;
              frame_valid_d = 1'b1;
              frame_start_d = ptr_q - PRE_OFF;
            end else begin
              state_d = S_POST;
              cnt_d   = CNT_W'(1);
            end
          end
        end
      end
      S_POST: begin
        if (sample_en) begin
          do_write = 1'b1;
          if (cnt_q == POST_LAST) begin
            cnt_d         = '0;
            state_d       = S_HOLDOFF;
            frame_valid_d = 1'b1;
            frame_start_d = trig_addr_q - PRE_OFF;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_HOLDOFF: begin
        if ((HOLDOFF_CYC <= 1) || (hold_q == HOLD_LAST)) begin
          hold_d  = '0;
          state_d = S_IDLE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (do_write) begin
      wr_en_d    = 1'b1;
      wr_addr_d  = ptr_q;
      wr_data_d  = ad_data;
      ptr_d      = ptr_q + 1'b1;
      prev_d     = ad_data;
      prev_vld_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      cnt_q         <= '0;
      hold_q        <= '0;
      prev_q        <= '0;
      prev_vld_q    <= 1'b0;
      mode_q        <= '0;
      trig_addr_q   <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      frame_start_q <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      hold_q        <= hold_d;
      prev_q        <= prev_d;
      prev_vld_q    <= prev_vld_d;
      mode_q        <= mode_d;
      trig_addr_q   <= trig_addr_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      frame_start_q <= frame_start_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign frame_start = frame_start_q;
  assign frame_valid = frame_valid_q;
  assign busy        = (state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST);

endmodule
